// File: rtl/uart_sys_pkg.sv
// Frame-level definitions shared by the UART command parser and the system controller.
// Parser FSM encodings and the default write/read opcodes.
package uart_sys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_ADDR = 2'd1,
    ST_GET_DATA = 2'd2,
    ST_HOLD     = 2'd3
  } parser_state_t;

  localparam logic [7:0] DEF_WR_CMD = 8'hAA;
  localparam logic [7:0] DEF_RD_CMD = 8'hBB;

endpackage

// File: rtl/uart_rx_gap_timer.sv
// Inter-byte gap counter: saturating count while running, expire when count >= limit (limit 0 disables).
// Expire is combinational from the registered count; no backpressure.
module uart_rx_gap_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  // >= rather than == so that lowering the limit below the running count still aborts
  assign o_expire = i_run && (i_limit != '0) && (r_cnt >= i_limit);

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// Assembles {op,addr[,data]} byte frames into one command; cmd_valid rises 1 cycle after the last byte.
// Command held until cmd_valid & cmd_ready; bytes arriving while held and not ready are dropped with ovr_err.
module uart_rx_cmd_parser
  import uart_sys_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 4,
  parameter int                    TIMEOUT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] WR_CMD        = DATA_WIDTH'(DEF_WR_CMD),
  parameter logic [DATA_WIDTH-1:0] RD_CMD        = DATA_WIDTH'(DEF_RD_CMD)
) (
  input  logic                     CLK_PARSER,
  input  logic                     RST_PARSER,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cyc,
  input  logic                     cmd_ready,
  output logic                     cmd_valid,
  output logic                     cmd_is_wr,
  output logic [ADDR_WIDTH-1:0]    cmd_addr,
  output logic [DATA_WIDTH-1:0]    cmd_data,
  output logic                     cmd_err,
  output logic                     ovr_err
);

  parser_state_t r_state;
  parser_state_t w_state_nxt;

  logic                  r_is_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_cmd_valid;
  logic                  r_cmd_is_wr;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_data;
  logic                  r_cmd_err;
  logic                  r_ovr_err;

  logic                  w_run;
  logic                  w_expire;
  logic                  w_timeout;
  logic                  w_xfer;
  logic                  w_is_op;
  logic                  w_addr_ok;

  logic                  w_is_wr_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_load_cmd;
  logic                  w_cmd_is_wr_nxt;
  logic [ADDR_WIDTH-1:0] w_cmd_addr_nxt;
  logic [DATA_WIDTH-1:0] w_cmd_data_nxt;
  logic                  w_cmd_err_nxt;
  logic                  w_ovr_err_nxt;

  assign w_run     = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
  assign w_timeout = w_expire && !rx_valid;
  assign w_xfer    = r_cmd_valid && cmd_ready;
  assign w_is_op   = (rx_data == WR_CMD) || (rx_data == RD_CMD);
  assign w_addr_ok = (rx_data[DATA_WIDTH-1:ADDR_WIDTH] == '0);

  uart_rx_gap_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_gap_timer (
    .i_clk    (CLK_PARSER),
    .i_rst    (RST_PARSER),
    .i_clear  (rx_valid || !w_run || w_timeout),
    .i_run    (w_run),
    .i_limit  (timeout_cyc),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK_PARSER or posedge RST_PARSER) begin
    if (RST_PARSER) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && w_is_op) w_state_nxt = ST_GET_ADDR;
      end
      ST_GET_ADDR: begin
        if (rx_valid) begin
          if (!w_addr_ok)   w_state_nxt = ST_IDLE;
          else if (r_is_wr) w_state_nxt = ST_GET_DATA;
          else              w_state_nxt = ST_HOLD;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_valid)       w_state_nxt = ST_HOLD;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_HOLD: begin
        // a byte landing in the transfer cycle starts the next frame with no bubble
        if (w_xfer) w_state_nxt = (rx_valid && w_is_op) ? ST_GET_ADDR : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_is_wr_nxt     = r_is_wr;
    w_addr_nxt      = r_addr;
    w_load_cmd      = 1'b0;
    w_cmd_is_wr_nxt = r_cmd_is_wr;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_data_nxt  = r_cmd_data;
    w_cmd_err_nxt   = 1'b0;
    w_ovr_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (rx_valid) begin
          if ((r_state == ST_HOLD) && !cmd_ready) begin
            w_ovr_err_nxt = 1'b1;
          end else if (w_is_op) begin
            w_is_wr_nxt = (rx_data == WR_CMD);
          end else begin
            w_cmd_err_nxt = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rx_valid) begin
          if (!w_addr_ok) begin
            w_cmd_err_nxt = 1'b1;
          end else begin
            w_addr_nxt = rx_data[ADDR_WIDTH-1:0];
            if (!r_is_wr) begin
              w_load_cmd      = 1'b1;
              w_cmd_is_wr_nxt = 1'b0;
              w_cmd_addr_nxt  = rx_data[ADDR_WIDTH-1:0];
              w_cmd_data_nxt  = '0;
            end
          end
        end else if (w_timeout) begin
          w_cmd_err_nxt = 1'b1;
        end
      end
      ST_GET_DATA: begin
        if (rx_valid) begin
          w_load_cmd      = 1'b1;
          w_cmd_is_wr_nxt = 1'b1;
          w_cmd_addr_nxt  = r_addr;
          w_cmd_data_nxt  = rx_data;
        end else if (w_timeout) begin
          w_cmd_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_PARSER or posedge RST_PARSER) begin
    if (RST_PARSER) begin
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_is_wr <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_cmd_err   <= 1'b0;
      r_ovr_err   <= 1'b0;
    end else begin
      r_is_wr     <= w_is_wr_nxt;
      r_addr      <= w_addr_nxt;
      r_cmd_valid <= (w_state_nxt == ST_HOLD);
      r_cmd_err   <= w_cmd_err_nxt;
      r_ovr_err   <= w_ovr_err_nxt;
      if (w_load_cmd) begin
        r_cmd_is_wr <= w_cmd_is_wr_nxt;
        r_cmd_addr  <= w_cmd_addr_nxt;
        r_cmd_data  <= w_cmd_data_nxt;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_is_wr = r_cmd_is_wr;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_data  = r_cmd_data;
  assign cmd_err   = r_cmd_err;
  assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser: per-cycle vector table plus hand-written timeout/reset sequences.
module tb_uart_rx_cmd_parser;

  logic        CLK_PARSER = 1'b0;
  logic        RST_PARSER;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] timeout_cyc;
  logic        cmd_ready;
  logic        cmd_valid;
  logic        cmd_is_wr;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_err;
  logic        ovr_err;

  int checks   = 0;
  int failures = 0;

  uart_rx_cmd_parser dut (
    .CLK_PARSER  (CLK_PARSER),
    .RST_PARSER  (RST_PARSER),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .timeout_cyc (timeout_cyc),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_is_wr   (cmd_is_wr),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_err     (cmd_err),
    .ovr_err     (ovr_err)
  );

  always #5 CLK_PARSER = ~CLK_PARSER;

  // one record per clock: inputs driven before the edge, outputs expected after it
  typedef struct {
    string      name;
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       e_valid;
    logic       e_wr;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    logic       e_err;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic vld, input logic [7:0] dat, input logic rdy,
                     input logic ev, input logic ew, input logic [3:0] ea, input logic [7:0] ed,
                     input logic ee, input logic eo);
    vec_t v;
    v.name = nm; v.vld = vld; v.dat = dat; v.rdy = rdy;
    v.e_valid = ev; v.e_wr = ew; v.e_addr = ea; v.e_data = ed; v.e_err = ee; v.e_ovr = eo;
    vecs.push_back(v);
  endtask

  // command fields only matter while cmd_valid is high
  function automatic logic [15:0] pack(input logic v, input logic e, input logic o,
                                       input logic w, input logic [3:0] a, input logic [7:0] d);
    logic [15:0] r;
    r = {v, e, o, 1'b0, 4'h0, 8'h00};
    if (v) r[12:0] = {w, a, d};
    return r;
  endfunction

  function automatic logic [15:0] act_packed();
    return pack(cmd_valid, cmd_err, ovr_err, cmd_is_wr, cmd_addr, cmd_data);
  endfunction

  function automatic logic [15:0] act_raw();
    return {cmd_valid, cmd_err, ovr_err, cmd_is_wr, cmd_addr, cmd_data};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {valid,err,ovr,wr,addr,data}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic vld, input logic [7:0] dat, input logic rdy);
    @(negedge CLK_PARSER);
    rx_valid  = vld;
    rx_data   = dat;
    cmd_ready = rdy;
    @(posedge CLK_PARSER);
    #1;
  endtask

  logic err_seen;

  initial begin
    RST_PARSER  = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    cmd_ready   = 1'b0;
    timeout_cyc = 16'd0;
    repeat (2) @(negedge CLK_PARSER);
    check("reset_state", act_raw(), 16'h0000);
    RST_PARSER = 1'b0;

    // write frame, consumer ready
    add("wr_op",     1, 8'hAA, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("wr_addr",   1, 8'h05, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("wr_data",   1, 8'h3C, 1, 1, 1, 4'h5, 8'h3C, 0, 0);
    add("wr_xfer",   0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    // read frame held 10 cycles by backpressure
    add("rd_op",     1, 8'hBB, 0, 0, 0, 4'h0, 8'h00, 0, 0);
    add("rd_addr",   1, 8'h0F, 0, 1, 0, 4'hF, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) add("rd_hold", 0, 8'h00, 0, 1, 0, 4'hF, 8'h00, 0, 0);
    add("rd_xfer",   0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    // bad opcode, then bad address returns to IDLE
    add("bad_op",    1, 8'h7E, 1, 0, 0, 4'h0, 8'h00, 1, 0);
    add("bad_op_end",0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("ba_op",     1, 8'hAA, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("bad_addr",  1, 8'h25, 1, 0, 0, 4'h0, 8'h00, 1, 0);
    add("ba_end",    0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("ba_idle",   1, 8'h05, 1, 0, 0, 4'h0, 8'h00, 1, 0);
    add("ba_idle2",  0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    // overrun while held, then byte in the transfer cycle starts a new frame
    add("ov_op",     1, 8'hBB, 0, 0, 0, 4'h0, 8'h00, 0, 0);
    add("ov_addr",   1, 8'h03, 0, 1, 0, 4'h3, 8'h00, 0, 0);
    add("ov_drop",   1, 8'hAA, 0, 1, 0, 4'h3, 8'h00, 0, 1);
    add("ov_after",  0, 8'h00, 0, 1, 0, 4'h3, 8'h00, 0, 0);
    add("ov_xfer_op",1, 8'hAA, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("ov_addr2",  1, 8'h07, 1, 0, 0, 4'h0, 8'h00, 0, 0);
    add("ov_data2",  1, 8'h11, 1, 1, 1, 4'h7, 8'h11, 0, 0);
    add("ov_xfer2",  0, 8'h00, 1, 0, 0, 4'h0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].vld, vecs[i].dat, vecs[i].rdy);
      check(vecs[i].name, act_packed(),
            pack(vecs[i].e_valid, vecs[i].e_err, vecs[i].e_ovr,
                 vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_data));
    end

    // timeout 20: 20 idle cycles are tolerated, the 21st aborts
    timeout_cyc = 16'd20;
    cyc(1, 8'hAA, 1);
    err_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 8'h00, 1);
      if (cmd_err) err_seen = 1'b1;
    end
    check("to_no_early_abort", {15'd0, err_seen}, 16'h0000);
    cyc(0, 8'h00, 1);
    check("to_abort", act_packed(), pack(0, 1, 0, 0, 4'h0, 8'h00));
    cyc(0, 8'h00, 1);
    check("to_abort_pulse", act_packed(), 16'h0000);
    cyc(1, 8'h05, 1);
    check("to_back_idle", act_packed(), pack(0, 1, 0, 0, 4'h0, 8'h00));
    cyc(0, 8'h00, 1);

    // byte lands in the expiry cycle: no abort, frame completes
    cyc(1, 8'hAA, 1);
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1);
    cyc(1, 8'h05, 1);
    check("to_byte_wins", act_packed(), 16'h0000);
    cyc(1, 8'h3C, 1);
    check("to_byte_wins_cmd", act_packed(), pack(1, 0, 0, 1, 4'h5, 8'h3C));
    cyc(0, 8'h00, 1);

    // lowering the limit below the running count aborts on the next cycle
    cyc(1, 8'hAA, 1);
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1);
    timeout_cyc = 16'd5;
    cyc(0, 8'h00, 1);
    check("to_lowered", act_packed(), pack(0, 1, 0, 0, 4'h0, 8'h00));
    cyc(0, 8'h00, 1);

    // timeout disabled across a gap longer than the counter range
    timeout_cyc = 16'd0;
    cyc(1, 8'hAA, 1);
    err_seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      cyc(0, 8'h00, 1);
      if (cmd_err) err_seen = 1'b1;
    end
    check("to_disabled", {15'd0, err_seen}, 16'h0000);
    cyc(1, 8'h09, 1);
    cyc(1, 8'h5A, 1);
    check("to_disabled_cmd", act_packed(), pack(1, 0, 0, 1, 4'h9, 8'h5A));
    cyc(0, 8'h00, 1);

    // reset mid-frame discards the partial write
    cyc(1, 8'hAA, 1);
    cyc(1, 8'h05, 1);
    @(negedge CLK_PARSER);
    rx_valid   = 1'b0;
    RST_PARSER = 1'b1;
    #1;
    check("rst_midframe", act_raw(), 16'h0000);
    @(negedge CLK_PARSER);
    RST_PARSER = 1'b0;
    cyc(1, 8'hBB, 1);
    check("rst_rd_op", act_packed(), 16'h0000);
    cyc(1, 8'h03, 1);
    check("rst_rd_cmd", act_packed(), pack(1, 0, 0, 0, 4'h3, 8'h00));
    cyc(0, 8'h00, 1);

    // reset while a command is held
    cyc(1, 8'hBB, 0);
    cyc(1, 8'h0C, 0);
    check("hold_before_rst", act_packed(), pack(1, 0, 0, 0, 4'hC, 8'h00));
    @(negedge CLK_PARSER);
    rx_valid   = 1'b0;
    RST_PARSER = 1'b1;
    #1;
    check("rst_in_hold", act_raw(), 16'h0000);
    @(negedge CLK_PARSER);
    RST_PARSER = 1'b0;
    cyc(0, 8'h00, 0);
    check("rst_hold_gone", act_packed(), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
